poly_pulse_synth: RTL

Parametrised polyphonic successor to the single-voice synth core. It runs NUM_VOICES independent pulse oscillators, each gated by its own ADSR envelope driven by one shared set of envelope rates, and sums them into a signed PCM mix. The mix feeds a first-order sigma-delta modulator that drives the 1-bit audio pin. The block sits between the FPGA top level (clock, reset, trigger pins) and the `data` output pad.

---
 rtl/synth_pkg.sv | 17 +
 rtl/synth_voice.sv | 73 +++++++
 rtl/poly_pulse_synth.sv | 65 ++++++
 3 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared envelope state, mix-width helper and default envelope rates
package synth_pkg;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;
  localparam int DEF_AI = 64;
  localparam int DEF_DI = 16;
  localparam int DEF_S  = 128;
  localparam int DEF_RI = 2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int mix_w(input int env_w, input int nv);
    return env_w + 1 + clog2(nv);
  endfunction
endpackage

// File: rtl/synth_voice.sv
// synth_voice: one ADSR envelope FSM gating one pulse oscillator, signed sample out
module synth_voice
  import synth_pkg::*;
#(
  parameter int ENV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    gate,
  input  logic                    gate_d,
  input  logic [CNT_W-1:0]        osc_count,
  input  logic [ENV_W-1:0]        ai,
  input  logic [ENV_W-1:0]        di,
  input  logic [ENV_W-1:0]        ri,
  input  logic [ENV_W-1:0]        s,
  output logic                    active,
  output logic signed [ENV_W:0]   sample
);
  localparam logic [ENV_W-1:0] MAXV = '1;
  env_state_t       state;
  logic [ENV_W-1:0] env;
  logic             phase;
  logic [CNT_W-1:0] cnt;
  logic             rise, fall;
  logic [ENV_W:0]   up;
  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;
  assign up = {1'b0, env} + {1'b0, ai};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      env   <= '0;
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      if (rise && state == IDLE) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (osc_count != '0) begin
        cnt   <= (cnt >= osc_count - 1'b1) ? '0 : cnt + 1'b1;
        phase <= (cnt >= osc_count - 1'b1) ? ~phase : phase;
      end
      // gate edges win over a coincident tick; the new state's step waits for the next tick
      if (rise) state <= ATTACK;
      else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) state <= RELEASE;
      else if (tick) begin
        case (state)
          ATTACK:
            if (ai == '0 || up >= {1'b0, MAXV}) begin
              env   <= MAXV;
              state <= DECAY;
            end else env <= up[ENV_W-1:0];
          DECAY:
            if (di == '0 || {1'b0, env} <= {1'b0, s} + {1'b0, di}) begin
              env   <= s;
              state <= SUSTAIN;
            end else env <= env - di;
          SUSTAIN: env <= s;
          RELEASE:
            if (ri == '0 || env <= ri) begin
              env   <= '0;
              state <= IDLE;
            end else env <= env - ri;
          default: ;
        endcase
      end
    end
  end
  assign active = state != IDLE;
  assign sample = (state == IDLE) ? '0 : phase ? $signed({1'b0, env}) : -$signed({1'b0, env});
endmodule

// File: rtl/poly_pulse_synth.sv
// poly_pulse_synth: NUM_VOICES ADSR-gated pulse voices mixed to PCM and a sigma-delta bit;
// POLY_PULSE_SYNTH_SIGMA_DELTA_EN enables the modulator, otherwise data is tied low.
module poly_pulse_synth
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ENV_W      = 8,
  parameter int CNT_W      = 16,
  parameter int TICK_DIV   = 50000
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_VOICES-1:0]                        trig,
  input  logic [NUM_VOICES*CNT_W-1:0]                  osc_count,
  input  logic [ENV_W-1:0]                             adsr_ai,
  input  logic [ENV_W-1:0]                             adsr_di,
  input  logic [ENV_W-1:0]                             adsr_ri,
  input  logic [ENV_W-1:0]                             adsr_s,
  output logic [NUM_VOICES-1:0]                        voice_active,
  output logic signed [mix_w(ENV_W, NUM_VOICES)-1:0]   pcm,
  output logic                                         data
);
  localparam int MW = mix_w(ENV_W, NUM_VOICES);
  localparam int TW = clog2(TICK_DIV);
  logic [TW-1:0]             tcnt;
  logic                      tick;
  logic [NUM_VOICES-1:0]     trig_r, trig_d;
  logic signed [ENV_W:0]     samples [NUM_VOICES];
  logic signed [MW-1:0]      mix;
  assign tick = tcnt == TW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt   <= '0;
      trig_r <= '0;
      trig_d <= '0;
      pcm    <= '0;
    end else begin
      tcnt   <= tick ? '0 : tcnt + 1'b1;
      trig_r <= trig;
      trig_d <= trig_r;
      pcm    <= mix;
    end
  end
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    synth_voice #(.ENV_W(ENV_W), .CNT_W(CNT_W)) u_voice (
      .clk(clk), .rst(rst), .tick(tick), .gate(trig_r[v]), .gate_d(trig_d[v]),
      .osc_count(osc_count[v*CNT_W +: CNT_W]), .ai(adsr_ai), .di(adsr_di), .ri(adsr_ri),
      .s(adsr_s), .active(voice_active[v]), .sample(samples[v])
    );
  end
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) mix = mix + MW'(samples[i]);
  end
`ifdef POLY_PULSE_SYNTH_SIGMA_DELTA_EN
  // the carry out of the offset-binary accumulator is the output bit
  logic [MW-1:0] acc;
  always_ff @(posedge clk) begin
    if (rst) {data, acc} <= '0;
    else {data, acc} <= {1'b0, acc} + {1'b0, ~pcm[MW-1], pcm[MW-2:0]};
  end
`else
  assign data = 1'b0;
`endif
endmodule
